control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired control unit for the single-bus CPU datapath (R1, R2, Y, ALU, Z).
- A free-running 4-step counter drives a combinational step/opcode decoder.
- The decoder issues one register-transfer micro-operation set per clock step, executing R1 <- R1 op R2, then copying the result to R2.
- Sits between the instruction decoder (supplies the 2-bit code) and the datapath register/ALU enables.

Parameters:
- none (step count fixed at 4; opcode width fixed at 2)

Ports:
- Clock  input  1  system clock, rising-edge active
- End  input  1  reset, asynchronous, active-high; clears the step counter and holds all outputs low; execution runs while low
- InstructionCode  input  2  00=Add, 01=Sub, 10=Mul, 11=Div
- R1in  output  1  load R1 from bus
- R1out  output  1  drive R1 onto bus
- R2in  output  1  load R2 from bus
- R2out  output  1  drive R2 onto bus
- Add  output  1  ALU add select
- Sub  output  1  ALU subtract select
- Mul  output  1  ALU multiply select
- Div  output  1  ALU divide select
- SelectY  output  1  ALU A-input mux selects Y register
- Yin  output  1  load Y from bus
- Zin  output  1  load Z from ALU
- Zout  output  1  drive Z onto bus

Behaviour:
- Clock is the only clock. End is an asynchronous, active-high reset.
- State:
  - 2-bit step counter, values T0..T3.
  - 2-bit latched opcode register.
- While End=1:
  - counter=T0, opcode register=00;
  - every output is 0, regardless of the step decode.
- Counter operation with End=0:
  - increments on each rising Clock edge: T0->T1->T2->T3->T0, wrapping with no idle state;
  - the first rising edge with End low at the edge moves T0->T1.
- Opcode register:
  - captures InstructionCode on the rising edge leaving T0;
  - holds that value through T1..T3, so input changes after T0 do not affect the running instruction.
- Outputs are combinational from (step, End, latched opcode), with no glitch-relevant extra latency. All outputs not listed for a step are 0.
  - T0: R1out=1, Yin=1
  - T1: R2out=1, SelectY=1, Zin=1, exactly one of Add/Sub/Mul/Div=1 per latched opcode (00 Add, 01 Sub, 10 Mul, 11 Div)
  - T2: Zout=1, R1in=1
  - T3: R1out=1, R2in=1
- One-hot guarantees:
  - at most one of Add/Sub/Mul/Div is high in any cycle, and only in T1;
  - never two bus drivers at once (R1out, R2out, Zout mutually exclusive).
- Reset mid-operation: End rising at any step forces outputs to 0 immediately (asynchronously) and restarts at T0 when released.
- Bench timing: End is released away from a rising edge (not coincident with it).

Decomposition:
- Shared package:
  - step encoding constants T0=2'd0, T1=2'd1, T2=2'd2, T3=2'd3;
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
- Sub-module control_step_counter: 2-bit wrapping counter with async active-high reset, outputting a one-hot 4-bit step vector.
- Top: instantiates the counter, holds the opcode register and the output decode.

Test Plan:
- Reset hold:
  - stimulus: End=1 for 3 cycles, InstructionCode=00;
  - required: all 12 outputs 0; step stays T0.
- Add instruction, clock period 10:
  - stimulus: code 00, release End mid-cycle;
  - required cycle 1: R1out,Yin;
  - cycle 2: R2out,SelectY,Zin,Add;
  - cycle 3: Zout,R1in;
  - cycle 4: R1out,R2in;
  - cycle 5: wraps to R1out,Yin.
- Opcode decode:
  - stimulus: repeat with codes 01, 10, 11;
  - required: T1 asserts Sub, Mul, Div respectively, with the other three ALU selects 0.
- Opcode latch:
  - stimulus: code 00 at the T0 edge, change to 11 during T1;
  - required: Add stays asserted in T1, Div is never asserted;
  - the next T1 (code 11 captured) asserts Div.
- Async reset mid-run:
  - stimulus: assert End midway through T2;
  - required: Zout/R1in drop to 0 immediately without waiting for an edge;
  - after release, the sequence restarts at T0.
- Exclusivity check:
  - stimulus: run 20 cycles of random codes;
  - required: in every cycle at most one bus driver high and at most one ALU select high.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the hardwired control unit: step numbers, opcodes,
// and the control word driven onto the single-bus datapath.
package control_unit_pkg;

   localparam logic [1:0] T0 = 2'd0;
   localparam logic [1:0] T1 = 2'd1;
   localparam logic [1:0] T2 = 2'd2;
   localparam logic [1:0] T3 = 2'd3;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef struct packed {
      logic r1_in;
      logic r1_out;
      logic r2_in;
      logic r2_out;
      logic add;
      logic sub;
      logic mul;
      logic div;
      logic select_y;
      logic y_in;
      logic z_in;
      logic z_out;
   } ctrl_word_t;

   // One-hot ALU select ordered {add, sub, mul, div}.
   function automatic logic [3:0] alu_select(input logic [1:0] op);
      logic [3:0] sel;
      sel = 4'b0000;
      case (op)
         OP_ADD:  sel = 4'b1000;
         OP_SUB:  sel = 4'b0100;
         OP_MUL:  sel = 4'b0010;
         OP_DIV:  sel = 4'b0001;
         default: sel = 4'b0000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/control_step_counter.sv
// Free-running T0..T3 step counter with asynchronous clear; the current
// step is presented one-hot so the decoder can test single bits.
module control_step_counter
   import control_unit_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   output logic [3:0] step_onehot_o
);

   logic [1:0] step_q;
   logic [1:0] step_d;

   // Two-bit wrap gives T3 -> T0 with no idle state.
   assign step_d = step_q + 2'd1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         step_q <= T0;
      end else begin
         step_q <= step_d;
      end
   end

   for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
      assign step_onehot_o[gi] = (step_q == 2'(gi));
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: runs R1 <- R1 op R2 then R2 <- R1 over four steps,
// decoding the step and latched opcode into datapath enables.
module control_unit
   import control_unit_pkg::*;
(
   input  logic       Clock,
   input  logic       End,
   input  logic [1:0] InstructionCode,
   output logic       R1in,
   output logic       R1out,
   output logic       R2in,
   output logic       R2out,
   output logic       Add,
   output logic       Sub,
   output logic       Mul,
   output logic       Div,
   output logic       SelectY,
   output logic       Yin,
   output logic       Zin,
   output logic       Zout
);

   logic [3:0] step_onehot;
   logic [1:0] opcode_q;
   logic [1:0] opcode_d;
   logic [3:0] alu_sel;
   ctrl_word_t ctrl_word;

   control_step_counter u_step_counter (
      .clk_i         (Clock),
      .rst_i         (End),
      .step_onehot_o (step_onehot)
   );

   // Opcode is sampled only on the edge leaving T0, so it is stable for T1.
   assign opcode_d = step_onehot[T0] ? InstructionCode : opcode_q;

   always_ff @(posedge Clock or posedge End) begin
      if (End) begin
         opcode_q <= OP_ADD;
      end else begin
         opcode_q <= opcode_d;
      end
   end

   assign alu_sel = alu_select(opcode_q);

   always_comb begin
      ctrl_word = '0;
      // End gates the decode directly so outputs drop without waiting for an edge.
      if (!End) begin
         if (step_onehot[T0]) begin
            ctrl_word.r1_out = 1'b1;
            ctrl_word.y_in   = 1'b1;
         end
         if (step_onehot[T1]) begin
            ctrl_word.r2_out   = 1'b1;
            ctrl_word.select_y = 1'b1;
            ctrl_word.z_in     = 1'b1;
            {ctrl_word.add, ctrl_word.sub, ctrl_word.mul, ctrl_word.div} = alu_sel;
         end
         if (step_onehot[T2]) begin
            ctrl_word.z_out = 1'b1;
            ctrl_word.r1_in = 1'b1;
         end
         if (step_onehot[T3]) begin
            ctrl_word.r1_out = 1'b1;
            ctrl_word.r2_in  = 1'b1;
         end
      end
   end

   assign R1in    = ctrl_word.r1_in;
   assign R1out   = ctrl_word.r1_out;
   assign R2in    = ctrl_word.r2_in;
   assign R2out   = ctrl_word.r2_out;
   assign Add     = ctrl_word.add;
   assign Sub     = ctrl_word.sub;
   assign Mul     = ctrl_word.mul;
   assign Div     = ctrl_word.div;
   assign SelectY = ctrl_word.select_y;
   assign Yin     = ctrl_word.y_in;
   assign Zin     = ctrl_word.z_in;
   assign Zout    = ctrl_word.z_out;

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against a step/opcode table model.
`timescale 1ns/1ps
module tb_control_unit;

   logic       Clock;
   logic       End;
   logic [1:0] InstructionCode;
   logic R1in, R1out, R2in, R2out, Add, Sub, Mul, Div, SelectY, Yin, Zin, Zout;

   int checks = 0;
   int errors = 0;

   // Model state: instruction step 0..3 and the opcode captured leaving step 0.
   int         m_step;
   logic [1:0] m_op;

   localparam int B_R1IN = 11, B_R1OUT = 10, B_R2IN = 9, B_R2OUT = 8;
   localparam int B_ADD = 7, B_SELY = 3, B_YIN = 2, B_ZIN = 1, B_ZOUT = 0;

   control_unit dut (
      .Clock           (Clock),
      .End             (End),
      .InstructionCode (InstructionCode),
      .R1in            (R1in),
      .R1out           (R1out),
      .R2in            (R2in),
      .R2out           (R2out),
      .Add             (Add),
      .Sub             (Sub),
      .Mul             (Mul),
      .Div             (Div),
      .SelectY         (SelectY),
      .Yin             (Yin),
      .Zin             (Zin),
      .Zout            (Zout)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [11:0] observed();
      return {R1in, R1out, R2in, R2out, Add, Sub, Mul, Div, SelectY, Yin, Zin, Zout};
   endfunction

   // Micro-operation table: which enables each step raises.
   function automatic logic [11:0] model_outputs(int step, logic [1:0] op, logic rst);
      logic [11:0] v;
      v = '0;
      if (!rst) begin
         case (step)
            0: begin v[B_R1OUT] = 1'b1; v[B_YIN] = 1'b1; end
            1: begin
               v[B_R2OUT] = 1'b1; v[B_SELY] = 1'b1; v[B_ZIN] = 1'b1;
               v[B_ADD - int'(op)] = 1'b1;
            end
            2: begin v[B_ZOUT] = 1'b1; v[B_R1IN] = 1'b1; end
            default: begin v[B_R1OUT] = 1'b1; v[B_R2IN] = 1'b1; end
         endcase
      end
      return v;
   endfunction

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_value(tag, 32'(observed()), 32'(model_outputs(m_step, m_op, End)));
      check_value({tag, "_bus_excl"}, 32'($countones({R1out, R2out, Zout}) <= 1), 32'd1);
      check_value({tag, "_alu_excl"}, 32'($countones({Add, Sub, Mul, Div}) <= 1), 32'd1);
   endtask

   task automatic set_end(input logic val);
      End = val;
      if (val) begin
         m_step = 0;
         m_op   = 2'b00;
      end
   endtask

   // One clock: advance the model on the rising edge, check on the falling edge.
   task automatic tick(input string tag);
      @(posedge Clock);
      if (!End) begin
         if (m_step == 0) m_op = InstructionCode;
         m_step = (m_step + 1) % 4;
      end
      @(negedge Clock);
      check_outputs(tag);
   endtask

   initial begin
      m_step = 0;
      m_op   = 2'b00;
      InstructionCode = 2'b00;
      set_end(1'b1);

      // Reset hold
      repeat (3) begin
         @(negedge Clock);
         check_outputs("rst_hold");
      end

      // Add sequence, End released mid-cycle
      set_end(1'b0);
      #1 check_outputs("add_c1");
      check_value("add_c1_r1out_yin", 32'({R1out, Yin}), 32'b11);
      tick("add_c2");
      check_value("add_c2_add", 32'(Add), 32'd1);
      tick("add_c3");
      tick("add_c4");
      tick("add_c5_wrap");
      check_value("add_c5_r1out_yin", 32'({R1out, Yin}), 32'b11);

      // Opcode decode for Sub, Mul, Div
      for (int c = 1; c < 4; c++) begin
         InstructionCode = 2'(c);
         tick("op_t1");
         check_value("op_alu_sel", 32'({Add, Sub, Mul, Div}), 32'(4'b1000 >> c));
         tick("op_t2");
         tick("op_t3");
         tick("op_t0");
      end

      // Opcode latch: change during T1 must not affect the running instruction
      InstructionCode = 2'b00;
      tick("latch_t1");
      check_value("latch_add", 32'({Add, Div}), 32'b10);
      InstructionCode = 2'b11;
      tick("latch_t2");
      tick("latch_t3");
      tick("latch_t0");
      tick("latch_next_t1");
      check_value("latch_div", 32'({Add, Div}), 32'b01);

      // Async reset midway through T2
      tick("arst_t2");
      check_value("arst_pre_zout_r1in", 32'({Zout, R1in}), 32'b11);
      #3 set_end(1'b1);
      #1 check_value("arst_zout_r1in", 32'({Zout, R1in}), 32'b00);
      check_outputs("arst_all");
      @(negedge Clock);
      check_outputs("arst_hold");
      set_end(1'b0);
      #1 check_outputs("arst_restart_t0");
      InstructionCode = 2'b10;
      tick("arst_restart_t1");

      // Random codes with occasional mid-cycle reset pulses
      for (int i = 0; i < 40; i++) begin
         InstructionCode = 2'($urandom_range(0, 3));
         tick("rand");
         if ($urandom_range(0, 9) == 0) begin
            #2 set_end(1'b1);
            #1 check_outputs("rand_rst");
            @(negedge Clock);
            set_end(1'b0);
            #1 check_outputs("rand_rel");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
